// File: rtl/serializer_pkg.sv
// Shared constants and FSM state type for the serializer transmitter.
// The PARITY state exists only when SERIALIZER_PARITY_EN is defined.
package serializer_pkg;

    localparam int WORD_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
`ifdef SERIALIZER_PARITY_EN
        , PARITY = 2'd2
`endif
    } state_t;

endpackage

// File: rtl/ser_bit_counter.sv
// Per-word bit counter: clears on word load, holds while stalled, flags the last data bit.
module ser_bit_counter #(
    parameter  int WORD_W = 8,
    localparam int CNT_W  = $clog2(WORD_W) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] count;

    // Clear takes priority so a word loaded on the final bit restarts at zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(WORD_W - 1));

endmodule

// File: rtl/serializer_tx.sv
// Parallel-to-serial transmitter, MSB first, with a one-word holding register and
// status_in flow control. Define SERIALIZER_PARITY_EN to append an even-parity bit.
module serializer_tx
    import serializer_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic              clock_1MHz,
    input  logic              rst,
    input  logic [WORD_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              status_in,
    output logic              data_out,
    output logic              write_out,
    output logic              busy_out
);

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] hold;
    logic              hold_vld;
    logic [WORD_W-1:0] shift;
    logic              load;
    logic              shift_en;
    logic              emit;
    logic              bit_next;
    logic              bit_last;
`ifdef SERIALIZER_PARITY_EN
    logic              par;
`endif

    ser_bit_counter #(.WORD_W(WORD_W)) u_bit_counter (
        .clk   (clock_1MHz),
        .rst   (rst),
        .clear (load),
        .inc   (shift_en),
        .last  (bit_last)
    );

    always_ff @(posedge clock_1MHz) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        emit       = 1'b0;
        bit_next   = shift[WORD_W-1];
        case (state)
            IDLE: begin
                if (hold_vld) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (status_in) begin
                    shift_en = 1'b1;
                    emit     = 1'b1;
                    if (bit_last) begin
`ifdef SERIALIZER_PARITY_EN
                        state_next = PARITY;
`else
                        if (hold_vld) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
`endif
                    end
                end
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                if (status_in) begin
                    emit     = 1'b1;
                    bit_next = par;
                    if (hold_vld) begin
                        load       = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Accept and drain are mutually exclusive: accept needs hold empty, drain needs it full.
    always_ff @(posedge clock_1MHz) begin
        if (rst) begin
            hold_vld  <= 1'b0;
            shift     <= '0;
            data_out  <= 1'b0;
            write_out <= 1'b0;
        end else begin
            if (valid_in && ready_out) begin
                hold_vld <= 1'b1;
            end else if (load) begin
                hold_vld <= 1'b0;
            end
            if (load) begin
                shift <= hold;
            end else if (shift_en) begin
                shift <= shift << 1;
            end
            write_out <= emit;
            if (emit) begin
                data_out <= bit_next;
            end
        end
    end

    // Word payload carries no reset; hold_vld qualifies it.
    always_ff @(posedge clock_1MHz) begin
        if (valid_in && ready_out) begin
            hold <= data_in;
        end
`ifdef SERIALIZER_PARITY_EN
        if (load) begin
            par <= ^hold;
        end
`endif
    end

    assign ready_out = ~hold_vld;
    assign busy_out  = (state != IDLE) || hold_vld;

endmodule

// File: tb/tb_serializer_tx.sv
// Self-checking bench for serializer_tx: directed scenarios plus a randomized run
// against a bit-queue reference model (parity bit expected when SERIALIZER_PARITY_EN is defined).
`timescale 1ns/1ps
module tb_serializer_tx;

    localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         valid_in = 1'b0;
    logic         ready_out;
    logic         status_in = 1'b0;
    logic         data_out;
    logic         write_out;
    logic         busy_out;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic got[$];
    logic expq[$];
    int   first_idx;
    int   last_idx;
    int   stall_bad;
    logic rdy_hist [0:63];

    serializer_tx #(.WORD_W(W)) dut (
        .clock_1MHz (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .status_in  (status_in),
        .data_out   (data_out),
        .write_out  (write_out),
        .busy_out   (busy_out)
    );

    always #500 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a word becomes its bits MSB first, then the XOR of the word if parity is on.
    function automatic void push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) expq.push_back(w[i]);
`ifdef SERIALIZER_PARITY_EN
        expq.push_back(^w);
`endif
    endfunction

    // Runs n cycles; status_in is low for cycle indices lo..hi. Drops valid_in once accepted.
    task automatic collect(input int n, input int lo, input int hi);
        logic rdy_before;
        logic acc;
        logic last_d;
        logic stalled;
        first_idx = -1;
        last_idx  = -1;
        stall_bad = 0;
        last_d    = data_out;
        for (int c = 1; c <= n; c++) begin
            stalled    = (c >= lo) && (c <= hi);
            status_in  = !stalled;
            rdy_before = ready_out;
            acc        = valid_in && rdy_before;
            step();
            if (acc) valid_in = 1'b0;
            rdy_hist[c] = ready_out;
            if (write_out) begin
                if (first_idx < 0) first_idx = c;
                last_idx = c;
                got.push_back(data_out);
            end
            if (stalled && (write_out !== 1'b0 || data_out !== last_d)) stall_bad++;
            last_d = data_out;
        end
        status_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_tests++; if (data_out !== 1'b0) begin n_fail++; $display("FAIL reset_data_out: got %b expected 0", data_out); end
        n_tests++; if (write_out !== 1'b0) begin n_fail++; $display("FAIL reset_write_out: got %b expected 0", write_out); end
        n_tests++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready_out: got %b expected 1", ready_out); end
        n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy_out: got %b expected 0", busy_out); end
    endtask

    task automatic test_single();
        got.delete(); expq.delete();
        push_word(8'hA5);
        status_in = 1'b1; data_in = 8'hA5; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        n_tests++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL single_ready_held: got %b expected 0", ready_out); end
        collect(16, 0, -1);
        n_tests++; if (first_idx !== 2) begin n_fail++; $display("FAIL single_latency: first pulse at k+%0d expected k+2", first_idx); end
        n_tests++; if (got.size() !== expq.size()) begin n_fail++; $display("FAIL single_count: got %0d pulses expected %0d", got.size(), expq.size()); end
        n_tests++; if (last_idx - first_idx + 1 !== got.size()) begin n_fail++; $display("FAIL single_contiguous: span %0d for %0d pulses", last_idx - first_idx + 1, got.size()); end
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            n_tests++; if (got[i] !== expq[i]) begin n_fail++; $display("FAIL single_bit%0d: got %b expected %b", i, got[i], expq[i]); end
        end
        n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b expected 0", busy_out); end
    endtask

    task automatic test_back_to_back();
        got.delete(); expq.delete();
        push_word(8'hFF);
        push_word(8'h00);
        status_in = 1'b1; data_in = 8'hFF; valid_in = 1'b1;
        step();
        data_in = 8'h00;
        collect(30, 0, -1);
        n_tests++; if (first_idx !== 2) begin n_fail++; $display("FAIL b2b_latency: first pulse at k+%0d expected k+2", first_idx); end
        n_tests++; if (got.size() !== 2 * NB) begin n_fail++; $display("FAIL b2b_count: got %0d pulses expected %0d", got.size(), 2 * NB); end
        n_tests++; if (last_idx - first_idx + 1 !== got.size()) begin n_fail++; $display("FAIL b2b_contiguous: span %0d for %0d pulses", last_idx - first_idx + 1, got.size()); end
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            n_tests++; if (got[i] !== expq[i]) begin n_fail++; $display("FAIL b2b_bit%0d: got %b expected %b", i, got[i], expq[i]); end
        end
        for (int c = 2; c <= NB; c++) begin
            n_tests++; if (rdy_hist[c] !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_held_k%0d: got %b expected 0", c, rdy_hist[c]); end
        end
        n_tests++; if (rdy_hist[NB + 1] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_drained: got %b expected 1", rdy_hist[NB + 1]); end
    endtask

    task automatic test_stall();
        got.delete(); expq.delete();
        push_word(8'h3C);
        status_in = 1'b1; data_in = 8'h3C; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        collect(20, 4, 6);
        n_tests++; if (stall_bad !== 0) begin n_fail++; $display("FAIL stall_pause: %0d stalled cycles pulsed or changed data_out, expected 0", stall_bad); end
        n_tests++; if (got.size() !== expq.size()) begin n_fail++; $display("FAIL stall_count: got %0d pulses expected %0d", got.size(), expq.size()); end
        n_tests++; if (last_idx !== NB + 4) begin n_fail++; $display("FAIL stall_last_pulse: at k+%0d expected k+%0d", last_idx, NB + 4); end
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            n_tests++; if (got[i] !== expq[i]) begin n_fail++; $display("FAIL stall_bit%0d: got %b expected %b", i, got[i], expq[i]); end
        end
    endtask

    task automatic test_reset_mid();
        got.delete(); expq.delete();
        status_in = 1'b1; data_in = 8'hF0; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        collect(5, 0, -1);
        n_tests++; if (got.size() !== 4) begin n_fail++; $display("FAIL midrst_partial: got %0d pulses expected 4", got.size()); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++; if (write_out !== 1'b0) begin n_fail++; $display("FAIL midrst_write_out: got %b expected 0", write_out); end
        n_tests++; if (data_out !== 1'b0) begin n_fail++; $display("FAIL midrst_data_out: got %b expected 0", data_out); end
        n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_out: got %b expected 0", busy_out); end
        n_tests++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_out: got %b expected 1", ready_out); end
        got.delete();
        push_word(8'h81);
        data_in = 8'h81; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        collect(16, 0, -1);
        n_tests++; if (first_idx !== 2) begin n_fail++; $display("FAIL midrst_latency: first pulse at k+%0d expected k+2", first_idx); end
        n_tests++; if (got.size() !== expq.size()) begin n_fail++; $display("FAIL midrst_count: got %0d pulses expected %0d", got.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            n_tests++; if (got[i] !== expq[i]) begin n_fail++; $display("FAIL midrst_bit%0d: got %b expected %b", i, got[i], expq[i]); end
        end
    endtask

`ifdef SERIALIZER_PARITY_EN
    task automatic test_parity();
        got.delete(); expq.delete();
        status_in = 1'b1; data_in = 8'h07; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        collect(16, 0, -1);
        n_tests++; if (got.size() !== 9) begin n_fail++; $display("FAIL parity_count: got %0d pulses expected 9", got.size()); end
        n_tests++; if (got.size() >= 9 && got[8] !== 1'b1) begin n_fail++; $display("FAIL parity_bit: got %b expected 1", got[8]); end
    endtask
`endif

    task automatic test_random();
        logic st_prev;
        int   bound;
        got.delete(); expq.delete();
        for (int c = 0; c < 600; c++) begin
            valid_in  = ($urandom_range(0, 1) == 1);
            data_in   = W'($urandom);
            status_in = ($urandom_range(0, 9) < 7);
            if (valid_in && ready_out) push_word(data_in);
            st_prev = status_in;
            step();
            if (write_out) begin
                got.push_back(data_out);
                n_tests++; if (!st_prev) begin n_fail++; $display("FAIL rand_pulse_when_stalled: cycle %0d write_out %b with status_in 0", c, write_out); end
            end
            n_tests++; if (busy_out !== (got.size() < expq.size())) begin n_fail++; $display("FAIL rand_busy: cycle %0d got %b expected %b", c, busy_out, got.size() < expq.size()); end
        end
        valid_in = 1'b0;
        status_in = 1'b1;
        bound = 0;
        while (busy_out && bound < 64) begin
            step();
            if (write_out) got.push_back(data_out);
            bound++;
        end
        n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL rand_drain_timeout: busy_out %b after %0d cycles, expected 0", busy_out, bound); end
        n_tests++; if (got.size() !== expq.size()) begin n_fail++; $display("FAIL rand_count: got %0d bits expected %0d", got.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            n_tests++; if (got[i] !== expq[i]) begin n_fail++; $display("FAIL rand_bit%0d: got %b expected %b", i, got[i], expq[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef SERIALIZER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serializer_tx.md
SERIALIZER_TX -- requirements
Module: serializer_tx

Interface
- REQ-001 The block SHALL have parameter WORD_W, default 8, giving the parallel word width in bits.
- REQ-002 The block SHALL have port clock_1MHz, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
- REQ-003 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
- REQ-004 The block SHALL have port data_in, input, WORD_W bits: the parallel word to transmit.
- REQ-005 The block SHALL have port valid_in, input, 1 bit: data_in is valid.
- REQ-006 The block SHALL have port ready_out, output, 1 bit: the holding register is empty and a word can be accepted.
- REQ-007 The block SHALL have port status_in, input, 1 bit: the downstream deserializer is ready for a bit (driven from its status_out).
- REQ-008 The block SHALL have port data_out, output, 1 bit: the serial bit.
- REQ-009 The block SHALL have port write_out, output, 1 bit: data_out is valid this cycle (drives the receiver's write_in).
- REQ-010 The block SHALL have port busy_out, output, 1 bit: a word is held or being shifted.

Function
- REQ-011 The block SHALL accept a word into the holding register on a rising edge when valid_in=1 and ready_out=1.
- REQ-012 ready_out SHALL equal the inverse of the holding-valid flag; no word is accepted while the holding register is full, including in the cycle it drains.
- REQ-013 The FSM SHALL have states IDLE, SHIFT and PARITY; PARITY SHALL exist only when SERIALIZER_PARITY_EN is defined.
- REQ-014 In IDLE with the holding register full, the block SHALL move the held word to the shift register, clear holding-valid, zero the bit counter and enter SHIFT.
- REQ-015 In SHIFT, on each edge with status_in=1, the block SHALL register write_out=1 and data_out=shift[WORD_W-1], shift left by one and increment the bit counter.
- REQ-016 In SHIFT, on each edge with status_in=0, the block SHALL register write_out=0, hold data_out, the shift register and the counter, and SHALL neither lose nor duplicate a bit.
- REQ-017 On emission of bit WORD_W-1, the block SHALL go to PARITY if enabled; otherwise it SHALL load the held word and stay in SHIFT if holding is full (no gap cycle), else go to IDLE.
- REQ-018 Latency: for a word accepted at edge k with status_in=1, it SHALL be loaded at k+1 and its first write_out pulse SHALL be high after edge k+2.
- REQ-019 Bits SHALL be sent MSB first, with exactly WORD_W write_out pulses per word (WORD_W+1 with parity).
- REQ-020 Outside active shifting, write_out SHALL be 0 and data_out SHALL hold its last value.
- REQ-021 busy_out SHALL be 1 when the state is not IDLE or holding-valid is set.
- REQ-022 The bit counter SHALL be $clog2(WORD_W)+1 bits wide and SHALL never wrap within a word.

Reset
- REQ-023 When rst=1 at an edge, the block SHALL go to IDLE, clear holding-valid, the shift register and the counter, and drive data_out=0, write_out=0, busy_out=0 and ready_out=1.
- REQ-024 Reset mid-word SHALL abandon the partial word, with no further write_out pulse for it.

Configuration
- REQ-025 With SERIALIZER_PARITY_EN defined, after the last data bit the block SHALL emit one even-parity bit (XOR of the word) in PARITY under the same status_in stall rule, then follow the REQ-017 next-word logic.
- REQ-026 Without SERIALIZER_PARITY_EN, PARITY and all parity logic SHALL be absent.

Structure
- REQ-027 Package serializer_pkg SHALL hold WORD_W_DEFAULT=8 and the FSM state enum typedef.
- REQ-028 The bit counter with stall and terminal-count flag SHALL be sub-module ser_bit_counter; the remaining logic SHALL stay in serializer_tx.

Verification
- REQ-029 Reset: rst=1 for 2 cycles -> data_out=0, write_out=0, ready_out=1, busy_out=0.
- REQ-030 Single word: 8'hA5 with status_in=1 -> 8 consecutive write_out pulses carrying 1,0,1,0,0,1,0,1; first pulse after edge k+2.
- REQ-031 Back-to-back: 8'hFF then 8'h00 -> 16 contiguous pulses (8 ones then 8 zeros); ready_out=0 while the second word is held.
- REQ-032 Stall: 8'h3C with status_in=0 during the 3rd-5th bit slots -> pulses pause, bit sequence 0,0,1,1,1,1,0,0 intact.
- REQ-033 Reset mid-word: rst after 4 bits of 8'hF0 -> outputs 0 next cycle; a following 8'h81 is sent cleanly as 1,0,0,0,0,0,0,1.
- REQ-034 Parity (macro defined): 8'h07 -> 9 pulses, 9th bit = 1.
